// File: rtl/seven_seg_capture.sv
// seven_seg_capture: snoops a multiplexed active-low 4-digit seven-segment
// scan bus, qualifies each scan slot for stability, decodes the segment
// pattern back to a hex nibble and holds the recovered digits together with
// per-digit valid/error flags.
//
// Optional feature macro: SEVEN_SEG_CAPTURE_SYNC_EN
//   defined   -> 2-flop synchronizer (reset to all-ones) on all 11 input bits
//   undefined -> inputs feed the capture register directly (same-clock loopback)
module seven_seg_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:6] seg,
  input  logic [3:0] an,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic [3:0] out2,
  output logic [3:0] out3,
  output logic [3:0] valid,
  output logic [3:0] err,
  output logic       upd,
  output logic [1:0] upd_idx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    STAB_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]    STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  // Pattern bit 6 is segment a, bit 0 is segment g. Result is {legal, nibble}.
  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    logic [4:0] d;
    case (p)
      7'b0000001: d = 5'b1_0000;
      7'b1001111: d = 5'b1_0001;
      7'b0010010: d = 5'b1_0010;
      7'b0000110: d = 5'b1_0011;
      7'b1001100: d = 5'b1_0100;
      7'b0100100: d = 5'b1_0101;
      7'b0100000: d = 5'b1_0110;
      7'b0001111: d = 5'b1_0111;
      7'b0000000: d = 5'b1_1000;
      7'b0000100: d = 5'b1_1001;
      7'b0001000: d = 5'b1_1010;
      7'b1100000: d = 5'b1_1011;
      7'b0110001: d = 5'b1_1100;
      7'b1000010: d = 5'b1_1101;
      7'b0110000: d = 5'b1_1110;
      7'b0111000: d = 5'b1_1111;
      default:    d = 5'b0_0000;
    endcase
    return d;
  endfunction

  logic [10:0]   raw_s;
  logic [10:0]   feed_s;
  logic [10:0]   r_r;
  logic [7:0]    stab_r;
  logic          same_s;
  logic          onehot_s;
  logic [1:0]    cap_idx_s;
  logic          capture_s;
  logic [4:0]    dec_s;
  logic [3:0]    out_r [4];
  logic [TW-1:0] tcnt_r [4];
  logic [3:0]    valid_r;
  logic [3:0]    err_r;
  logic          upd_r;
  logic [1:0]    upd_idx_r;

  // seg[0] (segment a) lands in bit 6, matching the decode table layout.
  assign raw_s = {an, seg};

`ifdef SEVEN_SEG_CAPTURE_SYNC_EN
  logic [10:0] sync1_r;
  logic [10:0] sync2_r;

  // Two-stage synchronizer; idles at all-ones (display dark).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 11'h7FF;
      sync2_r <= 11'h7FF;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  assign feed_s = sync2_r;
`else
  assign feed_s = raw_s;
`endif

  // Input register and saturating stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r    <= 11'h000;
      stab_r <= 8'd0;
    end else begin
      r_r <= feed_s;
      if (feed_s == r_r) begin
        if (stab_r != STAB_MAX) begin
          stab_r <= stab_r + 8'd1;
        end else begin
          stab_r <= stab_r;
        end
      end else begin
        stab_r <= 8'd0;
      end
    end
  end

  // Capture qualification: last step of the stable window on a single selected anode.
  always_comb begin
    same_s    = (feed_s == r_r);
    onehot_s  = 1'b1;
    cap_idx_s = 2'd0;
    case (r_r[10:7])
      4'b1110: cap_idx_s = 2'd0;
      4'b1101: cap_idx_s = 2'd1;
      4'b1011: cap_idx_s = 2'd2;
      4'b0111: cap_idx_s = 2'd3;
      default: onehot_s  = 1'b0;
    endcase
    capture_s = same_s && (stab_r == STAB_LAST) && onehot_s;
    dec_s     = decode_seg(r_r[6:0]);
  end

  // Per-digit timeout counters; a capture restarts that digit's count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        tcnt_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (capture_s && (cap_idx_s == 2'(k))) begin
          tcnt_r[k] <= '0;
        end else if (tcnt_r[k] != TO_MAX) begin
          tcnt_r[k] <= tcnt_r[k] + {{(TW-1){1'b0}}, 1'b1};
        end else begin
          tcnt_r[k] <= tcnt_r[k];
        end
      end
    end
  end

  // Digit value/flag registers; a capture takes priority over a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        out_r[k] <= 4'd0;
      end
      valid_r <= 4'b0000;
      err_r   <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (capture_s && (cap_idx_s == 2'(k))) begin
          if (dec_s[4]) begin
            out_r[k]   <= dec_s[3:0];
            valid_r[k] <= 1'b1;
            err_r[k]   <= 1'b0;
          end else begin
            valid_r[k] <= 1'b0;
            err_r[k]   <= 1'b1;
          end
        end else if (tcnt_r[k] == TO_LAST) begin
          valid_r[k] <= 1'b0;
        end else begin
          valid_r[k] <= valid_r[k];
        end
      end
    end
  end

  // Update strobe and held index of the most recent capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_r     <= 1'b0;
      upd_idx_r <= 2'd0;
    end else begin
      upd_r <= capture_s;
      if (capture_s) begin
        upd_idx_r <= cap_idx_s;
      end else begin
        upd_idx_r <= upd_idx_r;
      end
    end
  end

  assign out0    = out_r[0];
  assign out1    = out_r[1];
  assign out2    = out_r[2];
  assign out3    = out_r[3];
  assign valid   = valid_r;
  assign err     = err_r;
  assign upd     = upd_r;
  assign upd_idx = upd_idx_r;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed scenarios plus random
// scan traffic, compared every cycle against a run-length reference model.
module tb_seven_seg_capture;

  localparam int S = 4;
  localparam int T = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:6] seg;
  logic [3:0] an;
  logic [3:0] out0, out1, out2, out3, valid, err;
  logic       upd;
  logic [1:0] upd_idx;

  seven_seg_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid(valid), .err(err), .upd(upd), .upd_idx(upd_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Segment patterns for 0..F, bit 6 = segment a.
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference model state
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_out [4];
  bit          m_legal [4];
  logic [3:0]  m_err;
  int          m_age [4];
  logic        m_upd;
  logic [1:0]  m_idx;

  int tick_no = 0;
  int upd_seen;
  int upd_at;
  int cap3_at;
  int drop3_at;

  function automatic int decode_ref(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [3:0] an_of(input int k);
    return ~(4'b0001 << k);
  endfunction

  task automatic model_reset();
    m_prev = 11'h000;
    m_run  = 1;
    for (int k = 0; k < 4; k++) begin
      m_out[k] = 4'd0; m_legal[k] = 0; m_age[k] = 0;
    end
    m_err = 4'b0000; m_upd = 1'b0; m_idx = 2'd0;
  endtask

  // One clock edge in spec terms: count how long the applied value has
  // persisted; the (S+1)-th consecutive edge on one selected digit captures.
  task automatic model_step(input logic [3:0] a, input logic [6:0] s);
    int k; int n;
    if ({a, s} == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_prev = {a, s};
      m_run  = 1;
    end
    m_upd = 1'b0;
    for (int j = 0; j < 4; j++) if (m_age[j] < T) m_age[j]++;
    if (m_run == S + 1 && $countones(~a) == 1) begin
      k = 0;
      for (int j = 0; j < 4; j++) if (!a[j]) k = j;
      m_upd = 1'b1;
      m_idx = 2'(k);
      m_age[k] = 0;
      n = decode_ref(s);
      if (n >= 0) begin
        m_out[k] = 4'(n); m_legal[k] = 1; m_err[k] = 1'b0;
      end else begin
        m_legal[k] = 0; m_err[k] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] ev;
    for (int k = 0; k < 4; k++) ev[k] = m_legal[k] && (m_age[k] < T);
    check("outs", {out3, out2, out1, out0}, {m_out[3], m_out[2], m_out[1], m_out[0]});
    check("valid", valid, ev);
    check("err", err, m_err);
    check("upd", upd, m_upd);
    check("upd_idx", upd_idx, m_idx);
  endtask

  task automatic tick(input logic [3:0] a, input logic [6:0] s);
    an = a; seg = s;
    @(posedge clk);
    tick_no++;
    model_step(a, s);
    @(negedge clk);
    compare_all();
    if (upd === 1'b1) begin
      upd_seen++;
      if (upd_at < 0) upd_at = tick_no;
      if (upd_idx == 2'd3) cap3_at = tick_no;
    end
    if (cap3_at >= 0 && drop3_at < 0 && valid[3] === 1'b0) drop3_at = tick_no;
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_outs"}, {out3, out2, out1, out0}, 16'h0000);
    check({tag, "_valid"}, valid, 4'b0000);
    check({tag, "_err"}, err, 4'b0000);
    check({tag, "_upd"}, upd, 1'b0);
    check({tag, "_idx"}, upd_idx, 2'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int start;
    logic [3:0] a;
    logic [6:0] s;
    int hold;
    rst = 1'b1; an = 4'hF; seg = 7'h7F;
    model_reset();
    upd_seen = 0; upd_at = -1; cap3_at = -1; drop3_at = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Legal capture: one pulse, 5 edges after application
    upd_seen = 0; upd_at = -1; start = tick_no;
    repeat (10) tick(4'b1110, seg_tab[2]);
    check("legal_upd_count", upd_seen, 1);
    check("legal_latency", upd_at - start, 5);
    check("legal_out0", out0, 4'd2);
    check("legal_valid", valid, 4'b0001);

    // Full scan of 3,A,0,F (out3..out0)
    upd_seen = 0;
    repeat (2) begin
      tick(an_of(0), seg_tab[15]); repeat (5) tick(an_of(0), seg_tab[15]);
      repeat (6) tick(an_of(1), seg_tab[0]);
      repeat (6) tick(an_of(2), seg_tab[10]);
      repeat (6) tick(an_of(3), seg_tab[3]);
    end
    check("scan_upd_count", upd_seen, 8);
    check("scan_outs", {out3, out2, out1, out0}, 16'h3A0F);
    check("scan_valid", valid, 4'b1111);

    // Glitching digit 1 and blanking/ghost anodes: no captures
    upd_seen = 0;
    repeat (10) begin
      repeat (2) tick(4'b1101, seg_tab[5]);
      repeat (2) tick(4'b1101, seg_tab[6]);
    end
    repeat (20) tick(4'b1111, seg_tab[8]);
    repeat (20) tick(4'b1100, seg_tab[8]);
    check("glitch_upd_count", upd_seen, 0);
    check("glitch_out1", out1, 4'd0);

    // Illegal pattern on digit 2, then legal recapture
    repeat (6) tick(4'b1011, seg_tab[9]);
    check("ill_pre_valid2", valid[2], 1'b1);
    repeat (6) tick(4'b1011, 7'h7F);
    check("ill_out2", out2, 4'd9);
    check("ill_valid2", valid[2], 1'b0);
    check("ill_err2", err[2], 1'b1);
    repeat (6) tick(4'b1011, seg_tab[5]);
    check("recap_out2", out2, 4'd5);
    check("recap_valid2", valid[2], 1'b1);
    check("recap_err2", err[2], 1'b0);

    // Timeout of digit 3 exactly T edges after its capture
    cap3_at = -1; drop3_at = -1;
    repeat (6) tick(4'b0111, seg_tab[12]);
    repeat (60) tick(4'b1110, seg_tab[1]);
    check("timeout_edges", drop3_at - cap3_at, T);
    check("timeout_out3", out3, 4'd12);
    cap3_at = -1;

    // Reset mid-window, then a full window is needed again
    repeat (2) tick(4'b1110, seg_tab[7]);
    async_reset("rst_mid");
    upd_seen = 0; upd_at = -1; start = tick_no;
    repeat (10) tick(4'b1110, seg_tab[7]);
    check("rst_mid_latency", upd_at - start, 5);
    check("rst_mid_upd_count", upd_seen, 1);
    async_reset("rst_full");
    repeat (3) tick(4'b1110, seg_tab[7]);

    // Random scan traffic
    repeat (60) begin
      case ($urandom_range(0, 9))
        0: a = 4'b1111;
        1: begin
          a = 4'($urandom_range(0, 15));
          if ($countones(~a) < 2) a = 4'b0101;
        end
        default: a = an_of($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 4) == 0) s = 7'($urandom_range(0, 127));
      else s = seg_tab[$urandom_range(0, 15)];
      hold = $urandom_range(1, 12);
      repeat (hold) tick(a, s);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side companion to the seven-segment driver. Snoops the multiplexed, active-low `an`/`seg` scan bus of a Basys-3 4-digit display, qualifies each scan slot for stability, decodes the segment pattern back to a hex nibble, and holds the four recovered digits with per-digit valid/error flags. It is used for on-board loopback self-test and as a bench monitor on the display path.

## Interface
- `STABLE_CYCLES`, 16: consecutive `clk` edges `{an,seg}` must stay unchanged before a capture. Legal range 2..255.
- `TIMEOUT_CYCLES`, 200_000: `clk` edges without a capture of a digit before its `valid` drops. Must be at least 2 and exceed 4 scan slots.
- `clk` input 1: single system clock.
- `rst` input 1: asynchronous, active-high reset.
- `seg` input [0:6]: segment lines, active low; `seg[0]`=a … `seg[6]`=g.
- `an` input [3:0]: digit anodes, active low; `an[k]`=0 selects digit k.
- `out0`, `out1`, `out2`, `out3` output [3:0] each: last decoded nibble per digit.
- `valid` output [3:0]: `valid[k]`=1 when `outk` holds a fresh, legally decoded value.
- `err` output [3:0]: `err[k]`=1 when the last qualified capture for digit k was an illegal pattern.
- `upd` output 1: one-cycle pulse on every qualified capture.
- `upd_idx` output [1:0]: digit index of the capture flagged by `upd`; held between pulses.

## Operation
- **Input register.** Each edge, `{an,seg}` is registered into `r`.
- **Stability counter.**
  - `stab` increments, saturating at `STABLE_CYCLES`, when `r` equals its previous value.
  - `stab` clears to 0 on any difference.
- **Capture event.** Fires exactly once per stable window, on the edge where `stab` goes from `STABLE_CYCLES-1` to `STABLE_CYCLES`, and only if `r.an` has exactly one 0 bit.
  - If `an` is all-ones (blanking) or has multiple zeros (ghost), no capture occurs and `stab` still saturates.
- **Decode, seg[0:6] → nibble:**
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0000100→9, 0001000→A, 1100000→b
  - 0110001→C, 1000010→d, 0110000→E, 0111000→F
  - Every other pattern is illegal.
- **On capture of digit k, legal pattern:** `outk`←nibble, `valid[k]`←1, `err[k]`←0.
- **On capture of digit k, illegal pattern:** `outk` holds, `valid[k]`←0, `err[k]`←1.
- **Capture side effects (either case):**
  - `upd`=1 for one cycle.
  - `upd_idx`=k.
  - Digit k's timeout counter clears.
- **Timeout.**
  - Each digit has a saturating counter that increments every edge.
  - When a digit's counter reaches `TIMEOUT_CYCLES`, its `valid[k]`←0.
  - `outk` and `err[k]` are unaffected by timeout.
- **Same-cycle capture and timeout on one digit:** capture wins.
- **Reset (asynchronous, any time, including mid-window):** `out0..3`=0, `valid`=0, `err`=0, `upd`=0, `upd_idx`=0. `stab`, `r` and all timeout counters clear.

## Timing
- **Capture latency.** `{an,seg}` is applied before edge E0 and then held.
  - Capture registers update at edge E(`STABLE_CYCLES`).
  - `upd` is high in the cycle after E(`STABLE_CYCLES`).
  - Total latency is `STABLE_CYCLES`+1 edges including E0; the synchronizer option adds 2.
- **Glitch rejection.** A change shorter than `STABLE_CYCLES` edges produces no capture. The surrounding stable value is not recaptured until it is stable for a full window again.
- **Back-to-back captures** are at least `STABLE_CYCLES`+1 cycles apart.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- **`SEVEN_SEG_CAPTURE_SYNC_EN` defined:**
  - A 2-flop synchronizer is placed on all 11 input bits ahead of `r`.
  - Required when `an`/`seg` come from pins or another clock domain.
  - Latency is +2 cycles.
  - The synchronizer flops reset to all-ones (display idle).
- **`SEVEN_SEG_CAPTURE_SYNC_EN` undefined:** inputs feed `r` directly, for same-clock loopback.

## Test plan
- **Legal capture.** `STABLE_CYCLES`=4; hold `an`=1110, `seg`=0010010 for 10 cycles → exactly one `upd` pulse, 5 edges after application. `upd_idx`=0, `out0`=2, `valid`=0001, `err`=0000.
- **Full scan.** Drive the driver's scan of digits 3,A,0,F → `out3..out0`=3,A,0,F, `valid`=1111. Exactly one `upd` per slot, with `upd_idx` cycling 0,1,2,3.
- **Glitch and blanking.**
  - Toggle `seg` every 2 cycles on digit 1 → no `upd`, `out1` unchanged.
  - Drive `an`=1111 or 1100 for 20 cycles → no `upd`.
- **Illegal pattern.** Digit 2 first holds 9 (`valid[2]`=1), then gets `seg`=1111111 → `out2`=9, `valid[2]`=0, `err[2]`=1. Recapturing 5 → `out2`=5, `valid[2]`=1, `err[2]`=0.
- **Timeout.** `TIMEOUT_CYCLES`=50; capture digit 3, then hold `an`=1110 → `valid[3]` drops exactly 50 edges after its capture edge, while `out3` holds.
- **Reset.** Assert `rst` mid-window and again after a full capture → all outputs 0 immediately, without waiting for a clock edge. After release, a full new stability window is required before the next `upd`.
